// File: rtl/axi_burst_write_master.sv
// AXI3 burst write master: registered command, beat FIFO, per-beat address/strobe generation.
// Optional: define AXI_WM_BID_CHECK_EN to flag responses whose BID differs from MID as SLVERR.
module axi_burst_write_master #(
    parameter int          DATA_W     = 32,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [3:0]  MID        = 4'h0
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [31:0]         cmd_addr,
    input  logic [3:0]          cmd_len,
    input  logic [2:0]          cmd_size,
    input  logic [1:0]          cmd_burst,
    input  logic [DATA_W-1:0]   wd_data,
    input  logic                wd_valid,
    output logic                wd_ready,
    output logic                rsp_valid,
    output logic [1:0]          rsp_code,
    output logic                rsp_err,
    output logic [3:0]          AWID,
    output logic [31:0]         AWADDR,
    output logic [3:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic [1:0]          AWLOCK,
    output logic [3:0]          AWCACHE,
    output logic [2:0]          AWPROT,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [3:0]          WID,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [3:0]          BID,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY
);
    localparam int STRB_W = DATA_W / 8;
    localparam int AW     = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
    state_t state, state_nx;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              full, empty, push, pop;
    logic [3:0]        beat_cnt;
    logic [31:0]       beat_addr;
    logic              cmd_hs, aw_hs, b_hs;
    logic [1:0]        code_nx;
    logic              err_nx;

    assign AWID    = MID;
    assign WID     = MID;
    assign AWLOCK  = '0;
    assign AWCACHE = '0;
    assign AWPROT  = '0;

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !ARESET && (state == IDLE);
    assign AWVALID   = (state == ADDR);
    assign BREADY    = (state == RESP);
    assign WVALID    = (state == DATA) && !empty;
    assign WDATA     = mem[rd_ptr];
    assign WLAST     = WVALID && (beat_cnt == AWLEN);
    assign pop       = WVALID && WREADY;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts a push.
    assign wd_ready  = !ARESET && (!full || pop);
    assign push      = wd_valid && wd_ready;
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign aw_hs     = AWVALID && AWREADY;
    assign b_hs      = BVALID && BREADY;

    always_ff @(posedge ACLK) begin
        if (push)
            mem[wr_ptr] <= wd_data;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (cmd_hs) state_nx = ADDR;
            ADDR: if (aw_hs) state_nx = DATA;
            DATA: if (pop && WLAST) state_nx = RESP;
            RESP: if (b_hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            AWADDR   <= '0;
            AWLEN    <= '0;
            AWSIZE   <= '0;
            AWBURST  <= '0;
            beat_cnt <= '0;
        end else begin
            if (cmd_hs) begin
                AWADDR  <= cmd_addr;
                AWLEN   <= cmd_len;
                AWSIZE  <= cmd_size;
                AWBURST <= cmd_burst;
            end
            if (aw_hs)
                beat_cnt <= '0;
            else if (pop)
                beat_cnt <= beat_cnt + 4'd1;
        end
    end

    // Beat address and byte-lane strobe derived from the beat counter.
    logic [31:0] size_bytes, lane_mask, aligned, incr_addr, wrap_mask, wrap_addr;
    logic [31:0] lo32, hi32;

    always_comb begin
        size_bytes = 32'd1 << AWSIZE;
        lane_mask  = size_bytes - 32'd1;
        aligned    = AWADDR & ~lane_mask;
        incr_addr  = aligned + ({28'd0, beat_cnt} << AWSIZE);
        wrap_mask  = (({28'd0, AWLEN} + 32'd1) << AWSIZE) - 32'd1;
        wrap_addr  = (aligned & ~wrap_mask) | (incr_addr & wrap_mask);
        beat_addr  = AWADDR;
        if (beat_cnt != 4'd0) begin
            case (AWBURST)
                2'b01:   beat_addr = incr_addr;
                2'b10:   beat_addr = wrap_addr;
                default: beat_addr = AWADDR;
            endcase
        end
        lo32 = beat_addr & 32'(STRB_W - 1);
        hi32 = ((beat_addr & ~lane_mask) & 32'(STRB_W - 1)) + size_bytes - 32'd1;
        if (hi32 > 32'(STRB_W - 1))
            hi32 = 32'(STRB_W - 1);
        WSTRB = STRB_W'(((32'd1 << (hi32 + 32'd1)) - 32'd1) & ~((32'd1 << lo32) - 32'd1));
    end

`ifdef AXI_WM_BID_CHECK_EN
    always_comb begin
        code_nx = BRESP;
        err_nx  = BRESP[1];
        if (BID != MID) begin
            code_nx = 2'b10;
            err_nx  = 1'b1;
        end
    end
`else
    logic unused_bid;
    assign unused_bid = ^BID;
    always_comb begin
        code_nx = BRESP;
        err_nx  = BRESP[1];
    end
`endif

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rsp_valid <= 1'b0;
            rsp_code  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= b_hs;
            if (b_hs) begin
                rsp_code <= code_nx;
                rsp_err  <= err_nx;
            end
        end
    end
endmodule
